// File: rtl/fifo_burst_reader.sv
// Drain-side burst reader for a FWFT FIFO. Pops fixed-length bursts onto a registered valid/ready stream.
// Optional idle-timeout auto-flush is compiled in with `define FIFO_BURST_READER_TIMEOUT_EN.
module fifo_burst_reader #(
  parameter int C_DATA_WIDTH     = 128,
  parameter int C_BURST_LEN      = 8,
  parameter int C_TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [C_DATA_WIDTH-1:0] fifo_dataout,
  input  logic                    fifo_empty,
  input  logic [17:0]             fifo_count,
  output logic                    fifo_rden,
  input  logic                    flush,
  output logic                    m_valid,
  output logic [C_DATA_WIDTH-1:0] m_data,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic                    burst_done,
  output logic                    busy
);

  // state     | meaning
  // IDLE      | waiting for a full burst or a pending flush
  // READ      | popping beats while beats_left != 0
  // LAST_WAIT | final beat registered, waiting for it to be accepted
  typedef enum logic [1:0] {IDLE, READ, LAST_WAIT} state_t;

  localparam logic [17:0] BURST_CNT   = 18'(C_BURST_LEN);
  localparam logic [15:0] BURST_BEATS = 16'(C_BURST_LEN);

  if (C_BURST_LEN < 1 || C_BURST_LEN > 65535) begin : g_bad_burst_len
    $error("C_BURST_LEN must be in 1..65535");
  end
  if (C_TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("C_TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state, state_nxt;
  logic        flush_pend, flush_pend_nxt;
  logic [15:0] beats_left, beats_left_nxt;
  logic        pop;
  logic        last_accept;
  logic        timeout_hit;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(C_TIMEOUT_CYCLES - 1);
  logic [15:0] idle_cnt;
  logic        idle_run;

  assign idle_run = (state == IDLE) && (fifo_count != '0) && (fifo_count < BURST_CNT);

  // Saturates so a single timeout cannot re-fire before the flush burst launches.
  always_ff @(posedge clk) begin
    if (rst || !idle_run) idle_cnt <= '0;
    else if (idle_cnt != 16'hFFFF) idle_cnt <= idle_cnt + 16'd1;
  end

  assign timeout_hit = idle_run && (idle_cnt == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  assign pop = (state == READ) && (beats_left != '0) && !fifo_empty && (!m_valid || m_ready);
  assign fifo_rden   = pop;
  assign last_accept = (state == LAST_WAIT) && m_valid && m_ready && m_last;

  always_comb begin
    state_nxt      = state;
    flush_pend_nxt = flush_pend | flush | timeout_hit;
    beats_left_nxt = beats_left;
    case (state)
      IDLE: begin
        if (fifo_count >= BURST_CNT) begin
          state_nxt      = READ;
          beats_left_nxt = BURST_BEATS;
        end else if (flush_pend || flush) begin
          flush_pend_nxt = 1'b0;
          if (fifo_count != '0) begin
            state_nxt      = READ;
            beats_left_nxt = fifo_count[15:0];
          end
        end
      end
      READ: begin
        if (pop) begin
          beats_left_nxt = beats_left - 16'd1;
          if (beats_left == 16'd1) state_nxt = LAST_WAIT;
        end
      end
      LAST_WAIT: begin
        if (last_accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
      beats_left <= '0;
      busy       <= 1'b0;
      burst_done <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_pend <= flush_pend_nxt;
      beats_left <= beats_left_nxt;
      busy       <= (state_nxt != IDLE);
      burst_done <= last_accept;
      if (pop) begin
        m_valid <= 1'b1;
        m_data  <= fifo_dataout;
        m_last  <= (beats_left == 16'd1);
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a queue-based FWFT FIFO model on the read side.
module tb_fifo_burst_reader;
  localparam int DW = 32;
  localparam int BL = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fifo_dataout;
  logic          fifo_empty;
  logic [17:0]   fifo_count;
  logic          fifo_rden;
  logic          flush;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
  logic          burst_done;
  logic          busy;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .C_DATA_WIDTH(DW), .C_BURST_LEN(BL), .C_TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .fifo_dataout(fifo_dataout), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count), .fifo_rden(fifo_rden), .flush(flush), .m_valid(m_valid),
    .m_data(m_data), .m_last(m_last), .m_ready(m_ready), .burst_done(burst_done), .busy(busy)
  );

  logic [DW-1:0] fq[$];
  logic [DW-1:0] bd[$];
  logic          bl[$];
  int errors = 0, checks = 0;
  int rden_cnt, run_len, max_run, done_cnt, stall_viol, hold_viol;
  logic prev_stall, tog;
  logic [DW-1:0] prev_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_drive();
    fifo_empty   = (fq.size() == 0);
    fifo_count   = 18'(fq.size());
    fifo_dataout = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(base + DW'(i));
    fifo_drive();
  endtask

  task automatic clr_stats();
    bd.delete(); bl.delete();
    rden_cnt = 0; run_len = 0; max_run = 0; done_cnt = 0;
    stall_viol = 0; hold_viol = 0; prev_stall = 1'b0; prev_data = '0;
  endtask

  // One clock: sample the handshake just before the edge, then apply the pop to the FIFO model.
  task automatic tick();
    logic rd;
    if (tog) m_ready = ~m_ready;
    #1;
    rd = fifo_rden;
    if (m_valid && m_ready) begin bd.push_back(m_data); bl.push_back(m_last); end
    if (rd && m_valid && !m_ready) stall_viol++;
    if (prev_stall && (m_data !== prev_data)) hold_viol++;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    if (burst_done) done_cnt++;
    if (rd) begin
      rden_cnt++; run_len++;
      if (run_len > max_run) max_run = run_len;
    end else run_len = 0;
    @(posedge clk);
    #1;
    if (rd) void'(fq.pop_front());
    fifo_drive();
    #1;
  endtask

  task automatic run_n(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Last is expected on every blen-th beat and on the final beat.
  task automatic chk_beats(input string tag, input logic [DW-1:0] base, input int n, input int blen);
    int bad_d, bad_l;
    bad_d = 0; bad_l = 0;
    chk({tag, "_count"}, 64'(bd.size()), 64'(n));
    for (int i = 0; i < bd.size() && i < n; i++) begin
      if (bd[i] !== base + DW'(i)) bad_d++;
      if (bl[i] !== ((i == n - 1) || (i % blen == blen - 1))) bad_l++;
    end
    chk({tag, "_data"}, 64'(bad_d), 64'd0);
    chk({tag, "_last"}, 64'(bad_l), 64'd0);
  endtask

  initial begin
    int k, first;
    rst = 1'b1; flush = 1'b0; m_ready = 1'b1; tog = 1'b0;
    fifo_drive();
    clr_stats();
    run_n(3);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_burst_done", 64'(burst_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fifo_rden", 64'(fifo_rden), 64'd0);
    chk("rst_flush_pend", 64'(dut.flush_pend), 64'd0);
    chk("rst_beats_left", 64'(dut.beats_left), 64'd0);
    rst = 1'b0;
    tick();

    // Full burst, ready held high
    clr_stats();
    push(32'h0, 8);
    tick();
    chk("t1_busy_launch", 64'(busy), 64'd1);
    chk("t1_rden_launch", 64'(fifo_rden), 64'd1);
    chk("t1_valid_before", 64'(m_valid), 64'd0);
    tick();
    chk("t1_valid_first", 64'(m_valid), 64'd1);
    chk("t1_data_first", 64'(m_data), 64'h0);
    run_n(14);
    chk_beats("t1", 32'h0, 8, BL);
    chk("t1_rden_cnt", 64'(rden_cnt), 64'd8);
    chk("t1_rden_run", 64'(max_run), 64'd8);
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    chk("t1_busy_end", 64'(busy), 64'd0);

    // Backpressure with m_ready alternating 1,0,1,0
    clr_stats();
    m_ready = 1'b0; tog = 1'b1;
    push(32'h10, 8);
    run_n(40);
    tog = 1'b0; m_ready = 1'b1;
    chk_beats("t2", 32'h10, 8, BL);
    chk("t2_rden_in_stall", 64'(stall_viol), 64'd0);
    chk("t2_data_hold", 64'(hold_viol), 64'd0);
    chk("t2_done_cnt", 64'(done_cnt), 64'd1);

    // Short burst via flush, then flush with nothing buffered
    clr_stats();
    push(32'h20, 3);
    run_n(10);
    chk("t3_no_early_beats", 64'(bd.size()), 64'd0);
    chk("t3_idle_wait", 64'(busy), 64'd0);
    pulse_flush();
    run_n(15);
    chk_beats("t3", 32'h20, 3, BL);
    chk("t3_done_cnt", 64'(done_cnt), 64'd1);
    chk("t3_flush_pend", 64'(dut.flush_pend), 64'd0);
    clr_stats();
    pulse_flush();
    run_n(5);
    chk("t3e_no_beats", 64'(bd.size()), 64'd0);
    chk("t3e_flush_pend", 64'(dut.flush_pend), 64'd0);
    chk("t3e_busy", 64'(busy), 64'd0);

    // 20 words: two full bursts, flush during the second drains the last 4
    clr_stats();
    push(32'h100, 20);
    k = 0;
    while (done_cnt < 1 && k < 40) begin tick(); k++; end
    chk("t4_first_done_seen", 64'(done_cnt), 64'd1);
    run_n(2);
    chk("t4_busy_second", 64'(busy), 64'd1);
    pulse_flush();
    run_n(50);
    chk_beats("t4", 32'h100, 20, BL);
    chk("t4_done_cnt", 64'(done_cnt), 64'd3);
    chk("t4_fifo_count", 64'(fifo_count), 64'd0);
    chk("t4_busy_end", 64'(busy), 64'd0);

    // Reset after 4 accepted beats; 5 words popped, 4 remain
    clr_stats();
    push(32'h200, 9);
    k = 0;
    while (bd.size() < 4 && k < 30) begin tick(); k++; end
    chk("t5_four_beats_seen", 64'(bd.size()), 64'd4);
    m_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("t5_rst_valid", 64'(m_valid), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_rden", 64'(fifo_rden), 64'd0);
    chk("t5_fifo_left", 64'(fifo_count), 64'd4);
    rst = 1'b0; m_ready = 1'b1;
    clr_stats();
    run_n(30);
    chk("t5_no_beats", 64'(bd.size()), 64'd0);
    pulse_flush();
    run_n(20);
    chk_beats("t5", 32'h205, 4, BL);

    // Two words with no flush: timeout build drains them, default build holds them
    clr_stats();
    push(32'h300, 2);
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    first = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (first < 0 && rden_cnt > 0) first = i;
    end
    chk("t6_timeout_window", 64'(first >= 16 && first <= 18), 64'd1);
    run_n(10);
    chk_beats("t6", 32'h300, 2, BL);
`else
    first = 0;
    run_n(100);
    chk("t6_no_beats", 64'(bd.size() + first), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    pulse_flush();
    run_n(10);
    chk_beats("t6", 32'h300, 2, BL);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
